alu_operand_collector: RTL and testbench
========================================

// Module: alu_operand_collector
// PURPOSE
// - Upstream stage of the ALU core. Accepts stimulus-side operands that may arrive split across cycles.
// - Merges them into one complete operation and issues it to the ALU core over a valid/ready handshake.
// - Flags incomplete ops (operand timeout) and unsupported commands via o_err, so the core never sees partial data.
// PARAMETERS
// - WIDTH        8   operand width
// - CMD_WIDTH    4   command width
// - TIMEOUT_CYC  16  ce-qualified wait cycles allowed for a missing operand (>=2)
// PORTS
// - clk          in   1          clock
// - rst          in   1          asynchronous, active-high reset
// - ce           in   1          clock enable; 0 freezes all state, counters and outputs
// - opa          in   WIDTH      operand A
// - opb          in   WIDTH      operand B
// - cin          in   1          carry in
// - mode         in   1          1 = arithmetic, 0 = logical
// - cmd          in   CMD_WIDTH  command
// - inp_valid    in   2          [0] = opa valid, [1] = opb valid
// - in_ready     out  1          collector can accept input this cycle
// - o_opa        out  WIDTH      issued operand A
// - o_opb        out  WIDTH      issued operand B
// - o_cin        out  1          issued carry in
// - o_mode       out  1          issued mode
// - o_cmd        out  CMD_WIDTH  issued command
// - o_valid      out  1          issued op valid
// - o_ready      in   1          ALU core accepts op
// - o_err        out  1          issued op is erroneous: timeout or illegal cmd
// BEHAVIOUR
// - Reset: every output 0, state IDLE, wait counter 0. Mid-op reset discards any partial or pending op; o_valid drops immediately.
// - Operand need, need(mode,cmd):
//   - mode=1: cmd 0-3, 8-10 -> A+B; 4,5 -> A; 6,7 -> B; 11-15 illegal
//   - mode=0: cmd 0-5, 12, 13 -> A+B; 6, 8, 9 -> A; 7, 10, 11 -> B; 14, 15 illegal
// - All transitions require ce=1.
// - FSM IDLE (in_ready=1):
//   - inp_valid=00: ignored
//   - otherwise latch cmd/mode/cin plus each valid operand
//   - illegal cmd -> ISSUE with err=1
//   - all needed operands present -> ISSUE with err=0
//   - else -> WAIT, cnt=0
//   - Operands not needed by cmd are latched if valid, else held at 0.
// - FSM WAIT (in_ready=1):
//   - cmd/mode/cin inputs ignored
//   - only the missing operand is captured; an already-held operand is never overwritten
//   - on completion -> ISSUE, err=0
//   - else cnt++; when cnt reaches TIMEOUT_CYC-1 with the operand still missing -> ISSUE, err=1, missing operand = 0
//   - completion on the last allowed cycle wins over timeout
// - FSM ISSUE (in_ready=0):
//   - o_* registered and stable while o_valid=1 && !o_ready
//   - handshake o_valid && o_ready -> IDLE; o_valid deasserts the next cycle
// - Latency: op complete in cycle N -> o_valid=1 in cycle N+1. Throughput is one op per 2 cycles minimum (no bypass of IDLE).
// - The counter is TIMEOUT_CYC-wide-safe ($clog2(TIMEOUT_CYC)+1 bits) and cannot wrap.
// CONFIGURATION
// - ALU_COLLECT_STATS_EN defined:
//   - adds output stat_timeouts [15:0]: increments on each timeout issue, saturates at 16'hFFFF, reset 0
//   - adds output stat_illegal [15:0]: same rule, for illegal cmd
// - Undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - Package alu_collect_pkg:
//   - state enum {IDLE, WAIT, ISSUE}
//   - typedef op_need_t (2-bit A/B mask)
//   - function need_ops(mode, cmd) returning op_need_t + illegal flag
//   - mode encoding constants
// - One sub-module alu_collect_timer: ce-gated wait counter with clear/expire, parameter TIMEOUT_CYC.
// TESTING
// - Same-cycle ops:
//   - mode=1, cmd=0, opa=8'h05, opb=8'h03, inp_valid=11 -> next cycle o_valid=1, o_opa=05, o_opb=03, o_err=0
//   - o_ready held 0 for 3 cycles -> outputs stable
// - Split arrival:
//   - mode=1, cmd=0, inp_valid=01, opa=8'h10
//   - 5 cycles later inp_valid=10, opb=8'h20, cmd=3 -> issue o_cmd=0, o_opa=10, o_opb=20, o_err=0
// - Timeout:
//   - mode=0, cmd=0, inp_valid=10, opb=8'hAA, no opa for 16 ce cycles -> o_valid=1, o_err=1, o_opa=0
//   - stats build: stat_timeouts=1
// - Illegal and single-op cmds:
//   - mode=1, cmd=12, inp_valid=11 -> o_err=1 next cycle
//   - mode=1, cmd=4, inp_valid=01 -> immediate issue, o_err=0
// - Freeze/reset:
//   - ce=0 for 20 cycles during WAIT -> no timeout
//   - rst pulse while o_valid=1 -> o_valid=0 immediately, in_ready=1 after release

Source files
------------

// File: rtl/alu_collect_pkg.sv
// Shared types for the ALU operand collector: FSM states, operand-need mask
// and the command decode that says which operands each command consumes.
package alu_collect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // bit 0 = operand A needed, bit 1 = operand B needed
    typedef logic [1:0] op_need_t;

    localparam op_need_t NEED_NONE = 2'b00;
    localparam op_need_t NEED_A    = 2'b01;
    localparam op_need_t NEED_B    = 2'b10;
    localparam op_need_t NEED_AB   = 2'b11;

    localparam logic MODE_ARITH = 1'b1;
    localparam logic MODE_LOGIC = 1'b0;

    typedef struct packed {
        op_need_t need;
        logic     illegal;
    } need_res_t;

    // Commands wider than 4 bits decode as illegal above 15.
    function automatic need_res_t need_ops(input logic mode, input logic [31:0] cmd);
        need_res_t r;
        r.need    = NEED_NONE;
        r.illegal = 1'b1;
        if (mode == MODE_ARITH) begin
            case (cmd)
                32'd0, 32'd1, 32'd2, 32'd3,
                32'd8, 32'd9, 32'd10:        begin r.need = NEED_AB; r.illegal = 1'b0; end
                32'd4, 32'd5:                begin r.need = NEED_A;  r.illegal = 1'b0; end
                32'd6, 32'd7:                begin r.need = NEED_B;  r.illegal = 1'b0; end
                default: ;
            endcase
        end else if (mode == MODE_LOGIC) begin
            case (cmd)
                32'd0, 32'd1, 32'd2, 32'd3,
                32'd4, 32'd5, 32'd12, 32'd13: begin r.need = NEED_AB; r.illegal = 1'b0; end
                32'd6, 32'd8, 32'd9:          begin r.need = NEED_A;  r.illegal = 1'b0; end
                32'd7, 32'd10, 32'd11:        begin r.need = NEED_B;  r.illegal = 1'b0; end
                default: ;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_collect_timer.sv
// Wait counter for a missing operand: clock-enable gated, clears outside WAIT,
// flags expiry on its last allowed cycle and parks there instead of wrapping.
module alu_collect_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q != LAST)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (ce)
            cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/alu_operand_collector.sv
// Collects split-arrival operands into one op and issues it to the ALU core.
// Optional ALU_COLLECT_STATS_EN adds saturating timeout/illegal-cmd counters.
module alu_operand_collector
    import alu_collect_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CMD_WIDTH   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic                 cin,
    input  logic                 mode,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [1:0]           inp_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     o_opa,
    output logic [WIDTH-1:0]     o_opb,
    output logic                 o_cin,
    output logic                 o_mode,
    output logic [CMD_WIDTH-1:0] o_cmd,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_err
`ifdef ALU_COLLECT_STATS_EN
    ,
    output logic [15:0]          stat_timeouts,
    output logic [15:0]          stat_illegal
`endif
);

    state_t state_q, state_d;

    logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                 cin_q, cin_d, mode_q, mode_d, err_q, err_d;
    op_need_t             need_q, need_d, have_q, have_d;

    need_res_t in_need;
    op_need_t  cap;
    logic      wait_done, expire;

    assign in_need   = need_ops(mode, 32'(cmd));
    // Only operands the command needs and we do not yet hold are accepted.
    assign cap       = need_q & ~have_q & inp_valid;
    assign wait_done = (need_q & ~have_q & ~inp_valid) == NEED_NONE;

    alu_collect_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .clr_i    (state_q != WAIT),
        .inc_i    (state_q == WAIT),
        .expire_o (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else if (ce)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|inp_valid) begin
                if (in_need.illegal || (in_need.need & ~inp_valid) == NEED_NONE)
                    state_d = ISSUE;
                else
                    state_d = WAIT;
            end
            WAIT:    if (wait_done || expire) state_d = ISSUE;
            ISSUE:   if (o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset drops in_ready too, so the upstream never sees acceptance mid-reset.
    always_comb begin
        in_ready = (state_q != ISSUE) && !rst;
        o_valid  = (state_q == ISSUE);
    end

    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        cmd_d  = cmd_q;
        cin_d  = cin_q;
        mode_d = mode_q;
        need_d = need_q;
        have_d = have_q;
        err_d  = err_q;
        case (state_q)
            IDLE: if (|inp_valid) begin
                opa_d  = inp_valid[0] ? opa : '0;
                opb_d  = inp_valid[1] ? opb : '0;
                cmd_d  = cmd;
                cin_d  = cin;
                mode_d = mode;
                need_d = in_need.need;
                have_d = inp_valid;
                err_d  = in_need.illegal;
            end
            WAIT: begin
                if (cap[0]) opa_d = opa;
                if (cap[1]) opb_d = opb;
                have_d = have_q | cap;
                err_d  = expire && !wait_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q  <= '0;
            opb_q  <= '0;
            cmd_q  <= '0;
            cin_q  <= 1'b0;
            mode_q <= 1'b0;
            need_q <= NEED_NONE;
            have_q <= NEED_NONE;
            err_q  <= 1'b0;
        end else if (ce) begin
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            cmd_q  <= cmd_d;
            cin_q  <= cin_d;
            mode_q <= mode_d;
            need_q <= need_d;
            have_q <= have_d;
            err_q  <= err_d;
        end
    end

    assign o_opa  = opa_q;
    assign o_opb  = opb_q;
    assign o_cin  = cin_q;
    assign o_mode = mode_q;
    assign o_cmd  = cmd_q;
    assign o_err  = err_q;

`ifdef ALU_COLLECT_STATS_EN
    logic [15:0] stat_to_q, stat_to_d, stat_il_q, stat_il_d;
    logic        timeout_evt, illegal_evt;

    assign timeout_evt = (state_q == WAIT) && !wait_done && expire;
    assign illegal_evt = (state_q == IDLE) && (|inp_valid) && in_need.illegal;

    always_comb begin
        stat_to_d = stat_to_q;
        stat_il_d = stat_il_q;
        if (timeout_evt && stat_to_q != 16'hFFFF) stat_to_d = stat_to_q + 16'd1;
        if (illegal_evt && stat_il_q != 16'hFFFF) stat_il_d = stat_il_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_to_q <= '0;
            stat_il_q <= '0;
        end else if (ce) begin
            stat_to_q <= stat_to_d;
            stat_il_q <= stat_il_d;
        end
    end

    assign stat_timeouts = stat_to_q;
    assign stat_illegal  = stat_il_q;
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector; honours ALU_COLLECT_STATS_EN.
module tb_alu_operand_collector;

    logic       clk = 1'b0;
    logic       rst, ce;
    logic [7:0] opa, opb;
    logic       cin, mode;
    logic [3:0] cmd;
    logic [1:0] inp_valid;
    logic       in_ready;
    logic [7:0] o_opa, o_opb;
    logic       o_cin, o_mode;
    logic [3:0] o_cmd;
    logic       o_valid, o_ready, o_err;
`ifdef ALU_COLLECT_STATS_EN
    logic [15:0] stat_timeouts, stat_illegal;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_operand_collector #(.WIDTH(8), .CMD_WIDTH(4), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .opa       (opa),
        .opb       (opb),
        .cin       (cin),
        .mode      (mode),
        .cmd       (cmd),
        .inp_valid (inp_valid),
        .in_ready  (in_ready),
        .o_opa     (o_opa),
        .o_opb     (o_opb),
        .o_cin     (o_cin),
        .o_mode    (o_mode),
        .o_cmd     (o_cmd),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_err     (o_err)
`ifdef ALU_COLLECT_STATS_EN
        ,
        .stat_timeouts (stat_timeouts),
        .stat_illegal  (stat_illegal)
`endif
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] v,
                         input logic [7:0] a, input logic [7:0] b);
        mode = m; cmd = c; inp_valid = v; opa = a; opb = b;
    endtask

    task automatic handshake();
        inp_valid = 2'b00;
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; o_ready = 1'b0; cin = 1'b0;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00);
        tick(2);
        n_chk++;
        if ({o_valid, in_ready, o_err, o_opa, o_opb, o_cmd} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b r=%b e=%b a=%h b=%h c=%h want all 0",
                     o_valid, in_ready, o_err, o_opa, o_opb, o_cmd);
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if ({in_ready, o_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, o_valid);
        end
    endtask

    task automatic test_same_cycle();
        cin = 1'b1;
        drive(1'b1, 4'd0, 2'b11, 8'h05, 8'h03);
        tick();
        n_chk++;
        if ({o_valid, o_err, o_opa, o_opb, o_cmd, o_mode, o_cin, in_ready} !== {1'b1, 1'b0, 8'h05, 8'h03, 4'd0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL same_issue got v=%b e=%b a=%h b=%h c=%h m=%b ci=%b r=%b want 1 0 05 03 0 1 1 0",
                     o_valid, o_err, o_opa, o_opb, o_cmd, o_mode, o_cin, in_ready);
        end
        drive(1'b0, 4'd9, 2'b11, 8'hFF, 8'hEE);
        cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({o_valid, o_opa, o_opb, o_cmd, o_mode, o_cin} !== {1'b1, 8'h05, 8'h03, 4'd0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_stable cyc=%0d got v=%b a=%h b=%h c=%h want v=1 a=05 b=03 c=0", i, o_valid, o_opa, o_opb, o_cmd);
            end
        end
        handshake();
        n_chk++;
        if ({o_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL same_release got vld=%b rdy=%b want vld=0 rdy=1", o_valid, in_ready);
        end
    endtask

    task automatic test_split();
        drive(1'b1, 4'd0, 2'b01, 8'h10, 8'h00);
        tick();
        n_chk++;
        if ({o_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL split_wait got vld=%b rdy=%b want vld=0 rdy=1", o_valid, in_ready);
        end
        // A second opa while waiting for opb must not replace the held one.
        drive(1'b1, 4'd5, 2'b01, 8'h99, 8'h00);
        tick();
        inp_valid = 2'b00;
        tick(3);
        drive(1'b1, 4'd3, 2'b10, 8'h77, 8'h20);
        tick();
        n_chk++;
        if ({o_valid, o_err, o_cmd, o_opa, o_opb} !== {1'b1, 1'b0, 4'd0, 8'h10, 8'h20}) begin
            n_fail++;
            $display("FAIL split_issue got v=%b e=%b c=%h a=%h b=%h want 1 0 0 10 20", o_valid, o_err, o_cmd, o_opa, o_opb);
        end
        handshake();
    endtask

    task automatic test_timeout();
        drive(1'b0, 4'd0, 2'b10, 8'h00, 8'hAA);
        tick();
        inp_valid = 2'b00;
        tick(15);
        n_chk++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early got vld=%b want 0", o_valid);
        end
        tick();
        n_chk++;
        if ({o_valid, o_err, o_opa, o_opb} !== {1'b1, 1'b1, 8'h00, 8'hAA}) begin
            n_fail++;
            $display("FAIL timeout_issue got v=%b e=%b a=%h b=%h want 1 1 00 AA", o_valid, o_err, o_opa, o_opb);
        end
`ifdef ALU_COLLECT_STATS_EN
        n_chk++;
        if (stat_timeouts !== 16'd1) begin
            n_fail++;
            $display("FAIL stat_timeouts_1 got %0d want 1", stat_timeouts);
        end
`endif
        handshake();
        // Operand arriving on the last allowed cycle beats the timeout.
        drive(1'b0, 4'd0, 2'b10, 8'h00, 8'hAA);
        tick();
        inp_valid = 2'b00;
        tick(15);
        drive(1'b0, 4'd0, 2'b01, 8'h55, 8'h00);
        tick();
        n_chk++;
        if ({o_valid, o_err, o_opa, o_opb} !== {1'b1, 1'b0, 8'h55, 8'hAA}) begin
            n_fail++;
            $display("FAIL last_cycle_win got v=%b e=%b a=%h b=%h want 1 0 55 AA", o_valid, o_err, o_opa, o_opb);
        end
        handshake();
    endtask

    task automatic test_illegal_single();
        drive(1'b1, 4'd12, 2'b11, 8'h01, 8'h02);
        tick();
        n_chk++;
        if ({o_valid, o_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL illegal_arith got v=%b e=%b want 1 1", o_valid, o_err);
        end
        handshake();
        drive(1'b0, 4'd14, 2'b01, 8'h01, 8'h02);
        tick();
        n_chk++;
        if ({o_valid, o_err, o_opa, o_opb} !== {1'b1, 1'b1, 8'h01, 8'h00}) begin
            n_fail++;
            $display("FAIL illegal_logic got v=%b e=%b a=%h b=%h want 1 1 01 00", o_valid, o_err, o_opa, o_opb);
        end
`ifdef ALU_COLLECT_STATS_EN
        n_chk++;
        if (stat_illegal !== 16'd2) begin
            n_fail++;
            $display("FAIL stat_illegal_2 got %0d want 2", stat_illegal);
        end
`endif
        handshake();
        drive(1'b1, 4'd4, 2'b01, 8'h3C, 8'h00);
        tick();
        n_chk++;
        if ({o_valid, o_err, o_opa, o_opb, o_cmd} !== {1'b1, 1'b0, 8'h3C, 8'h00, 4'd4}) begin
            n_fail++;
            $display("FAIL single_a got v=%b e=%b a=%h b=%h c=%h want 1 0 3C 00 4", o_valid, o_err, o_opa, o_opb, o_cmd);
        end
        handshake();
        drive(1'b0, 4'd11, 2'b10, 8'h00, 8'hC3);
        tick();
        n_chk++;
        if ({o_valid, o_err, o_opa, o_opb} !== {1'b1, 1'b0, 8'h00, 8'hC3}) begin
            n_fail++;
            $display("FAIL single_b got v=%b e=%b a=%h b=%h want 1 0 00 C3", o_valid, o_err, o_opa, o_opb);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        o_ready = 1'b1;
        drive(1'b1, 4'd1, 2'b11, 8'h11, 8'h22);
        tick();
        n_chk++;
        if ({o_valid, o_opa, o_opb} !== {1'b1, 8'h11, 8'h22}) begin
            n_fail++;
            $display("FAIL b2b_first got v=%b a=%h b=%h want 1 11 22", o_valid, o_opa, o_opb);
        end
        drive(1'b1, 4'd2, 2'b11, 8'h33, 8'h44);
        tick();
        n_chk++;
        if ({o_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_gap got vld=%b rdy=%b want 0 1", o_valid, in_ready);
        end
        tick();
        n_chk++;
        if ({o_valid, o_opa, o_opb, o_cmd} !== {1'b1, 8'h33, 8'h44, 4'd2}) begin
            n_fail++;
            $display("FAIL b2b_second got v=%b a=%h b=%h c=%h want 1 33 44 2", o_valid, o_opa, o_opb, o_cmd);
        end
        inp_valid = 2'b00;
        tick();
        o_ready = 1'b0;
    endtask

    task automatic test_freeze_reset();
        drive(1'b1, 4'd0, 2'b01, 8'h42, 8'h00);
        tick();
        inp_valid = 2'b00;
        tick(10);
        ce = 1'b0;
        tick(20);
        n_chk++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_no_timeout got vld=%b want 0", o_valid);
        end
        ce = 1'b1;
        tick(5);
        n_chk++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_resume_early got vld=%b want 0", o_valid);
        end
        tick();
        n_chk++;
        if ({o_valid, o_err, o_opa, o_opb} !== {1'b1, 1'b1, 8'h42, 8'h00}) begin
            n_fail++;
            $display("FAIL freeze_timeout got v=%b e=%b a=%h b=%h want 1 1 42 00", o_valid, o_err, o_opa, o_opb);
        end
`ifdef ALU_COLLECT_STATS_EN
        n_chk++;
        if (stat_timeouts !== 16'd2) begin
            n_fail++;
            $display("FAIL stat_timeouts_2 got %0d want 2", stat_timeouts);
        end
`endif
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({o_valid, in_ready, o_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_midop got vld=%b rdy=%b err=%b want 0 0 0", o_valid, in_ready, o_err);
        end
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if ({o_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_midop_release got vld=%b rdy=%b want 0 1", o_valid, in_ready);
        end
`ifdef ALU_COLLECT_STATS_EN
        n_chk++;
        if ({stat_timeouts, stat_illegal} !== 32'd0) begin
            n_fail++;
            $display("FAIL stat_reset got to=%0d il=%0d want 0 0", stat_timeouts, stat_illegal);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_split();
        test_timeout();
        test_illegal_single();
        test_back_to_back();
        test_freeze_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
